// File: rtl/mux_arbiter.sv
// Three-requester round-robin arbiter with a held data mux.
// A winner's data is captured on grant and presented on y for HOLD cycles,
// followed by a one-cycle ack pulse, unless the winner withdraws first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; arbitrate among req starting at ptr
//   BUSY  | grant held, y/y_valid driven, cnt counts down the hold time
//   ACK   | one-cycle completion pulse on ack[sel]
module mux_arbiter #(
   parameter int W    = 2,
   parameter int HOLD = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   req,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   output logic [1:0]   sel,
   output logic [2:0]   gnt,
   output logic [W-1:0] y,
   output logic         y_valid,
   output logic [2:0]   ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

   state_t       state;
   logic [1:0]   ptr;
   logic [3:0]   cnt;

   // padded copy so a 2-bit index can never select past the vector
   logic [3:0]   req_x;
   logic [1:0]   cand0;
   logic [1:0]   cand1;
   logic [1:0]   cand2;
   logic [1:0]   win_idx;
   logic [2:0]   win_onehot;
   logic [W-1:0] win_data;
   logic [2:0]   sel_onehot;
   logic [1:0]   sel_next;

   // modulo-3 successor of a requester index
   function automatic logic [1:0] next_idx(input logic [1:0] i);
      logic [1:0] r;
      r = (i == 2'd2) ? 2'd0 : i + 2'd1;
      return r;
   endfunction

   function automatic logic [2:0] to_onehot(input logic [1:0] i);
      logic [2:0] r;
      case (i)
         2'd0:    r = 3'b001;
         2'd1:    r = 3'b010;
         2'd2:    r = 3'b100;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   assign req_x = {1'b0, req};

   // round-robin scan order: ptr, ptr+1, ptr+2
   always_comb begin
      cand0 = ptr;
      cand1 = next_idx(ptr);
      cand2 = next_idx(cand1);
      if (req_x[cand0])
         win_idx = cand0;
      else if (req_x[cand1])
         win_idx = cand1;
      else
         win_idx = cand2;
   end

   // winner's data and grant vector, sampled on the edge that leaves IDLE
   always_comb begin
      win_onehot = to_onehot(win_idx);
      case (win_idx)
         2'd0:    win_data = d0;
         2'd1:    win_data = d1;
         2'd2:    win_data = d2;
         default: win_data = '0;
      endcase
   end

   assign sel_onehot = to_onehot(sel);
   assign sel_next   = next_idx(sel);

   // arbitration FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ptr     <= 2'd0;
         cnt     <= 4'd0;
         sel     <= 2'b00;
         gnt     <= 3'b000;
         y       <= '0;
         y_valid <= 1'b0;
         ack     <= 3'b000;
      end else begin
         case (state)
            ST_IDLE: begin
               ack <= 3'b000;
               if (|req) begin
                  sel     <= win_idx;
                  gnt     <= win_onehot;
                  y       <= win_data;
                  y_valid <= 1'b1;
                  cnt     <= CNT_LOAD;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!req_x[sel]) begin
                  // winner withdrew: drop the grant silently, still rotate
                  gnt     <= 3'b000;
                  y_valid <= 1'b0;
                  ptr     <= sel_next;
                  state   <= ST_IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  gnt     <= 3'b000;
                  y_valid <= 1'b0;
                  ack     <= sel_onehot;
                  state   <= ST_ACK;
               end
            end
            ST_ACK: begin
               ack   <= 3'b000;
               ptr   <= sel_next;
               state <= ST_IDLE;
            end
            default: begin
               gnt     <= 3'b000;
               y_valid <= 1'b0;
               ack     <= 3'b000;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed plus randomized bench for mux_arbiter against a transaction-level model.
module tb_mux_arbiter;
   localparam int W    = 2;
   localparam int HOLD = 2;

   logic         clk;
   logic         rst_n;
   logic [2:0]   req;
   logic [W-1:0] d0, d1, d2;
   logic [1:0]   sel;
   logic [2:0]   gnt;
   logic [W-1:0] y;
   logic         y_valid;
   logic [2:0]   ack;

   int errors = 0;
   int checks = 0;

   // model: who owns the grant, how long it has been valid, pending ack
   int           m_owner;
   int           m_age;
   int           m_last;
   int           m_ptr;
   bit           m_ack;
   logic [W-1:0] m_y;

   mux_arbiter #(.W(W), .HOLD(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2),
      .sel(sel), .gnt(gnt), .y(y), .y_valid(y_valid), .ack(ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_last  = 0;
      m_ptr   = 0;
      m_ack   = 1'b0;
      m_y     = '0;
   endtask

   task automatic model_edge(input logic [2:0] r, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c);
      logic [W-1:0] dv [3];
      bit found;
      dv[0] = a; dv[1] = b; dv[2] = c;
      if (m_ack) begin
         m_ack = 1'b0;
         m_ptr = (m_last + 1) % 3;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (!found && r[idx]) begin
               found   = 1'b1;
               m_owner = idx;
               m_last  = idx;
               m_age   = 1;
               m_y     = dv[idx];
            end
         end
      end else if (!r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 3;
         m_owner = -1;
      end else if (m_age == HOLD) begin
         m_ack   = 1'b1;
         m_owner = -1;
      end else begin
         m_age++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [2:0] e_gnt, e_ack;
      e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      e_ack = m_ack ? 3'(1 << m_last) : 3'b000;
      chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
      chk({tag, ".y_valid"}, 32'(y_valid), 32'(m_owner >= 0));
      chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
      chk({tag, ".sel"}, 32'(sel), 32'(m_last));
      chk({tag, ".y"}, 32'(y), 32'(m_y));
   endtask

   task automatic step(input string tag, input logic [2:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
      req = r; d0 = a; d1 = b; d2 = c;
      @(posedge clk);
      model_edge(r, a, b, c);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] r;
      rst_n = 1'b1;
      req = 3'b000; d0 = '0; d1 = '0; d2 = '0;
      model_reset();
      #1;
      rst_n = 1'b0;
      #3;
      check_all("por");
      @(negedge clk);
      rst_n = 1'b1;

      // single request
      step("single1", 3'b001, 2'b10, 2'b00, 2'b00);
      chk("single1.gnt_lit", 32'(gnt), 32'h1);
      chk("single1.y_lit", 32'(y), 32'h2);
      step("single2", 3'b001, 2'b10, 2'b00, 2'b00);
      step("single3", 3'b001, 2'b10, 2'b00, 2'b00);
      chk("single3.ack_lit", 32'(ack), 32'h1);
      chk("single3.yv_lit", 32'(y_valid), 32'h0);
      step("single4", 3'b000, 2'b10, 2'b00, 2'b00);

      // round robin with all requesters held
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step("rr", 3'b111, 2'b01, 2'b10, 2'b11);
         if (i == 1)  chk("rr.y0", 32'(y), 32'h1);
         if (i == 5)  chk("rr.y1", 32'(y), 32'h2);
         if (i == 9)  chk("rr.y2", 32'(y), 32'h3);
         if (i == 13) chk("rr.y3", 32'(y), 32'h1);
      end
      step("rr_end", 3'b000, 2'b01, 2'b10, 2'b11);

      // capture: d0 changes while busy
      step("cap1", 3'b001, 2'b10, 2'b00, 2'b00);
      step("cap2", 3'b001, 2'b01, 2'b00, 2'b00);
      chk("cap2.y_held", 32'(y), 32'h2);
      step("cap3", 3'b001, 2'b01, 2'b00, 2'b00);
      step("cap4", 3'b000, 2'b01, 2'b00, 2'b00);

      // priority skip: ptr=1, req=101 -> requester 2, then 0
      step("skip1", 3'b101, 2'b00, 2'b00, 2'b11);
      chk("skip1.sel", 32'(sel), 32'h2);
      step("skip2", 3'b101, 2'b00, 2'b00, 2'b11);
      step("skip3", 3'b101, 2'b00, 2'b00, 2'b11);
      step("skip4", 3'b101, 2'b00, 2'b00, 2'b11);
      step("skip5", 3'b101, 2'b00, 2'b00, 2'b11);
      chk("skip5.sel", 32'(sel), 32'h0);
      step("skip6", 3'b000, 2'b00, 2'b00, 2'b11);

      // withdrawal by requester 1, then 011 goes to requester 0
      step("wd1", 3'b010, 2'b01, 2'b10, 2'b00);
      step("wd2", 3'b010, 2'b01, 2'b10, 2'b00);
      step("wd3", 3'b000, 2'b01, 2'b10, 2'b00);
      chk("wd3.ack", 32'(ack), 32'h0);
      step("wd4", 3'b011, 2'b01, 2'b10, 2'b00);
      chk("wd4.gnt", 32'(gnt), 32'h1);
      step("wd5", 3'b000, 2'b01, 2'b10, 2'b00);

      // asynchronous reset in the middle of a grant
      step("rb1", 3'b100, 2'b00, 2'b00, 2'b11);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      step("rb2", 3'b000, 2'b00, 2'b00, 2'b00);

      // randomized traffic
      r = 3'b000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         step("rand", r, 2'($urandom), 2'($urandom), 2'($urandom));
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter W, default 2: data width of each requester and of y.
REQ-002 Parameter HOLD, default 2, legal range 1..15: number of cycles y_valid stays high per grant.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  3  request per requester; bit i belongs to requester i.
REQ-006 d0, d1, d2  input  W each  data of requesters 0, 1 and 2.
REQ-007 sel  output  2  index of the granted requester, encoded 2'b00/2'b01/2'b10; 2'b11 is never driven.
REQ-008 gnt  output  3  one-hot grant, high for the whole BUSY state only.
REQ-009 y  output  W  captured data of the granted requester.
REQ-010 y_valid  output  1  y is valid, high for the whole BUSY state only.
REQ-011 ack  output  3  one-cycle completion pulse to the served requester.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-013 The FSM SHALL hold a round-robin pointer ptr (0..2), which marks the highest-priority requester.
REQ-014 IDLE with req==0: the FSM SHALL stay in IDLE, and all outputs except sel and y SHALL be 0.
REQ-015 IDLE with any req bit set: the winner SHALL be the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
REQ-016 On the edge that leaves IDLE, the block SHALL do all of the following:
- sel <= winner index
- gnt <= one-hot of the winner
- y <= d[winner], sampled at that edge
- y_valid <= 1
- cnt <= HOLD-1
- state <= BUSY
REQ-017 In BUSY, y and sel SHALL hold their captured values, even if d changes.
REQ-018 In BUSY with cnt!=0 and req[sel]==1, cnt SHALL decrement.
REQ-019 In BUSY with cnt==0 and req[sel]==1, the next state SHALL be ACK; y_valid is therefore high for exactly HOLD cycles.
REQ-020 ACK SHALL last one cycle: ack[sel]=1, gnt=0, y_valid=0.
REQ-021 On the edge that leaves ACK, the next state SHALL be IDLE and ptr SHALL become (sel+1) mod 3.
REQ-022 Withdrawal: if req[sel] is 0 while in BUSY, the next state SHALL be IDLE with no ack pulse.
REQ-023 On a withdrawal, ptr SHALL still become (sel+1) mod 3 and y_valid SHALL fall at that edge.
REQ-024 Requests from non-granted requesters that arrive or drop during BUSY or ACK SHALL be ignored until IDLE.
REQ-025 A requester that keeps req high after ack SHALL re-enter arbitration normally.
REQ-026 Latency from a req rising in IDLE to y_valid SHALL be 1 cycle.
REQ-027 Minimum grant period SHALL be HOLD+2 cycles.
REQ-028 sel and y SHALL retain their last values in IDLE and ACK.
REQ-029 gnt, y_valid and ack SHALL never be nonzero in the same cycle as one another, except gnt together with y_valid.

Reset
REQ-030 While rst_n==0, the block SHALL force, independent of clk:
- state=IDLE
- ptr=0, cnt=0
- sel=2'b00, gnt=0
- y=0, y_valid=0, ack=0
REQ-031 Reset asserted mid-BUSY or mid-ACK SHALL abort immediately, with no ack pulse.
REQ-032 The first edge after rst_n deasserts SHALL perform normal IDLE arbitration.

Verification (W=2, HOLD=2)
REQ-033 Single request: req=001, d0=2'b10.
- edge1: gnt=001, sel=00, y=10, y_valid=1
- edge3: ack=001, y_valid=0
- edge4: IDLE, ptr=1
REQ-034 Round-robin: req=111 held, d0=01, d1=10, d2=11.
- grant order 0, 1, 2, 0
- y values 01, 10, 11, 01
- one grant every 4 cycles
REQ-035 Capture: change d0 from 10 to 01 during BUSY -> y stays 10.
REQ-036 Withdrawal: req=010, then req drops to 000 after 1 BUSY cycle.
- next state IDLE, ack stays 000
- ptr=2
- a subsequent req=011 is granted to requester 0
REQ-037 Reset mid-BUSY: pull rst_n low -> gnt, y_valid, y, sel all 0 before the next clk edge; no ack.
REQ-038 Priority skip: ptr=1, req=101 -> requester 2 wins; afterwards ptr=0.
